// File: rtl/clock_set_ctrl.sv
// Time-setting control for the 24-hour BCD timekeeper: debounced mode/inc buttons,
// hour/minute edit sequence, one-cycle commit strobe and blink mask for the edited field.

module clock_set_debounce #(
  parameter int CNT_W  = 26,
  parameter int DB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // sync1 != sync2 means the synchronised level changes this edge, so the window restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      if (sync1 != sync2) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= ~sync2;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end
endmodule

module clock_set_ctrl #(
  parameter int CNT_W      = 26,
  parameter int DB_CYC     = 1_000_000,
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int BLINK_CYC  = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BT_mode,
  input  logic       BT_inc,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  output logic [7:0] set_hh,
  output logic [7:0] set_mm,
  output logic [7:0] set_ss,
  output logic       load,
  output logic       editing,
  output logic [2:0] blank
);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  typedef enum logic [1:0] {RUN, EDIT_HH, EDIT_MM, COMMIT} state_t;

  state_t           state;
  state_t           state_next;
  logic             mode_lvl;
  logic             mode_q;
  logic             mode_press;
  logic             inc_lvl;
  logic             inc_evt;
  logic             repeating;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] blink_cnt;
  logic             phase;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  clock_set_debounce #(.CNT_W(CNT_W), .DB_CYC(DB_CYC)) u_db_mode (
    .clk(clk), .rst(rst), .button(BT_mode), .level(mode_lvl)
  );

  clock_set_debounce #(.CNT_W(CNT_W), .DB_CYC(DB_CYC)) u_db_inc (
    .clk(clk), .rst(rst), .button(BT_inc), .level(inc_lvl)
  );

  assign mode_press = mode_lvl & ~mode_q;
  assign inc_evt    = inc_lvl & (repeating ? (hold_cnt == REP_LAST) : (hold_cnt == HOLD_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else begin
      mode_q <= mode_lvl;
      if (!inc_lvl) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end else if (inc_evt) begin
        hold_cnt  <= '0;
        repeating <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + ONE;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mode_press) state_next = EDIT_HH;
      EDIT_HH: if (mode_press) state_next = EDIT_MM;
      EDIT_MM: if (mode_press) state_next = COMMIT;
      COMMIT:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // A mode press always takes priority over an increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      set_hh <= 8'h00;
      set_mm <= 8'h00;
    end else begin
      state <= state_next;
      case (state)
        RUN: if (mode_press) begin
          set_hh <= cur_hh;
          set_mm <= cur_mm;
        end
        EDIT_HH: if (!mode_press && inc_evt) set_hh <= bcd_inc(set_hh, 8'h23);
        EDIT_MM: if (!mode_press && inc_evt) set_mm <= bcd_inc(set_mm, 8'h59);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if ((state_next != state) || !editing) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + ONE;
    end
  end

  always_comb begin
    blank = 3'b000;
    case (state)
      EDIT_HH: blank = {phase, 2'b00};
      EDIT_MM: blank = {1'b0, phase, 1'b0};
      default: blank = 3'b000;
    endcase
  end

  assign editing = (state == EDIT_HH) || (state == EDIT_MM);
  assign load    = (state == COMMIT);
  assign set_ss  = 8'h00;
endmodule
